// File: rtl/bcd3_countdown.sv
// Three-digit BCD down-counter with a cycle prescaler and an IDLE/RUN/EXPIRED FSM.
// It holds at 000 on expiry, and only a load or a reset releases it.
module bcd3_countdown #(
    parameter int TICK_DIV = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] LD0,
    input  logic [3:0] LD1,
    input  logic [3:0] LD2,
    output logic [3:0] BCD0,
    output logic [3:0] BCD1,
    output logic [3:0] BCD2,
    output logic       running,
    output logic       done,
    output logic       expired
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_EXPIRED = 2'd2;

    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [2:0][3:0] cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            running_q, expired_q;

    logic [2:0][3:0] ld_raw;
    logic [2:0][3:0] ld_sat;
    logic [2:0][3:0] cnt_dec;
    logic [2:0]      borrow;

    assign ld_raw[0] = LD0;
    assign ld_raw[1] = LD1;
    assign ld_raw[2] = LD2;
    assign borrow[0] = 1'b1;

    // Per-digit saturation of the load value and a ripple-borrow decrement.
    // At 000 the decrement result is never used, so the 999 wrap cannot reach the count.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            assign ld_sat[gi]  = (ld_raw[gi] > 4'd9) ? 4'd9 : ld_raw[gi];
            assign cnt_dec[gi] = !borrow[gi]          ? cnt_q[gi] :
                                 (cnt_q[gi] == 4'd0)  ? 4'd9      :
                                                        cnt_q[gi] - 4'd1;
            if (gi < 2) begin : g_borrow
                assign borrow[gi+1] = borrow[gi] && (cnt_q[gi] == 4'd0);
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (load) begin
            cnt_d   = ld_sat;
            state_d = ST_IDLE;
            presc_d = '0;
        end else if (stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_IDLE;
                presc_d = '0;
            end
        end else if (start && (state_q == ST_IDLE)) begin
            if (cnt_q == '0) begin
                state_d = ST_EXPIRED;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
                presc_d = '0;
            end
        end else if (state_q == ST_RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                cnt_d   = cnt_dec;
                if (cnt_dec == '0) begin
                    state_d = ST_EXPIRED;
                    done_d  = 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            running_q <= (state_d == ST_RUN);
            expired_q <= (state_d == ST_EXPIRED);
        end
    end

    assign BCD0    = cnt_q[0];
    assign BCD1    = cnt_q[1];
    assign BCD2    = cnt_q[2];
    assign running = running_q;
    assign done    = done_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_bcd3_countdown.sv
// Bench for bcd3_countdown: an integer-valued reference model is checked every cycle,
// and directed scenarios pin hand-computed values.
module tb_bcd3_countdown;

    localparam int TICK = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load  = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic [3:0] LD0 = 4'd0, LD1 = 4'd0, LD2 = 4'd0;
    logic [3:0] BCD0, BCD1, BCD2;
    logic       running, done, expired;

    int total = 0;
    int bad   = 0;

    bcd3_countdown #(.TICK_DIV(TICK)) dut (
        .clock(clock), .reset(reset), .load(load), .start(start), .stop(stop),
        .LD0(LD0), .LD1(LD1), .LD2(LD2),
        .BCD0(BCD0), .BCD1(BCD1), .BCD2(BCD2),
        .running(running), .done(done), .expired(expired)
    );

    always #5 clock = ~clock;

    // Reference model: the count is a plain integer, and mode 0/1/2 means idle/run/expired.
    int m_val   = 0;
    int m_mode  = 0;
    int m_cyc   = 0;
    bit m_done  = 1'b0;

    function automatic int sat9(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_val  <= 0;
            m_mode <= 0;
            m_cyc  <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (load) begin
                m_val  <= sat9(LD2) * 100 + sat9(LD1) * 10 + sat9(LD0);
                m_mode <= 0;
                m_cyc  <= 0;
            end else if (stop) begin
                if (m_mode == 1) begin
                    m_mode <= 0;
                    m_cyc  <= 0;
                end
            end else if (start && m_mode == 0) begin
                if (m_val == 0) begin
                    m_mode <= 2;
                    m_done <= 1'b1;
                end else begin
                    m_mode <= 1;
                    m_cyc  <= 0;
                end
            end else if (m_mode == 1) begin
                if (m_cyc + 1 == TICK) begin
                    m_cyc <= 0;
                    m_val <= m_val - 1;
                    if (m_val - 1 == 0) begin
                        m_mode <= 2;
                        m_done <= 1'b1;
                    end
                end else begin
                    m_cyc <= m_cyc + 1;
                end
            end
        end
    end

    // Compare the DUT with the model on every clock, just after the active edge.
    always begin
        @(posedge clock);
        #1;
        if (!reset) begin
            total++;
            if (int'(BCD2) * 100 + int'(BCD1) * 10 + int'(BCD0) != m_val ||
                BCD0 > 4'd9 || BCD1 > 4'd9 || BCD2 > 4'd9 ||
                running !== (m_mode == 1) || expired !== (m_mode == 2) || done !== m_done) begin
                bad++;
                $display("FAIL model t=%0t got=%h%h%h r%b d%b e%b want=%03d mode%0d d%b",
                         $time, BCD2, BCD1, BCD0, running, done, expired, m_val, m_mode, m_done);
            end
        end
    end

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic chk_all(input string name, input logic [11:0] digits, input logic [2:0] rde);
        chk({name, "_bcd"}, {BCD2, BCD1, BCD0}, digits);
        chk({name, "_flags"}, {9'd0, running, done, expired}, {9'd0, rde});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_load(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
        load = 1'b1; LD2 = d2; LD1 = d1; LD0 = d0;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        cyc(2);
        chk_all("reset", 12'h000, 3'b000);
        reset = 1'b0;
        cyc(1);

        // 1: borrow chain 100 -> 099
        do_load(4'd1, 4'd0, 4'd0);
        do_start();
        chk_all("t1_run", 12'h100, 3'b100);
        cyc(3);
        chk_all("t1_pre_tick", 12'h100, 3'b100);
        cyc(1);
        chk_all("t1_099", 12'h099, 3'b100);

        // 2: expiry of 002
        do_load(4'd0, 4'd0, 4'd2);
        do_start();
        cyc(4);
        chk_all("t2_001", 12'h001, 3'b100);
        cyc(4);
        chk_all("t2_expire", 12'h000, 3'b011);
        cyc(1);
        chk_all("t2_done_off", 12'h000, 3'b001);
        cyc(20);
        chk_all("t2_hold", 12'h000, 3'b001);

        // 3: saturation of illegal load digits
        do_load(4'hF, 4'd3, 4'hC);
        chk_all("t3_sat", 12'h939, 3'b000);

        // 4: start at 000 expires immediately
        do_load(4'd0, 4'd0, 4'd0);
        do_start();
        chk_all("t4_done", 12'h000, 3'b011);
        cyc(10);
        chk_all("t4_nowrap", 12'h000, 3'b001);

        // 5: pause and resume with a full interval
        do_load(4'd0, 4'd1, 4'd0);
        do_start();
        cyc(5);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        chk_all("t5_stop", 12'h009, 3'b000);
        cyc(10);
        chk_all("t5_held", 12'h009, 3'b000);
        do_start();
        cyc(3);
        chk_all("t5_resume_pre", 12'h009, 3'b100);
        cyc(1);
        chk_all("t5_008", 12'h008, 3'b100);

        // 6: load beats start, then async reset mid-run
        load = 1'b1; start = 1'b1; LD2 = 4'd0; LD1 = 4'd5; LD0 = 4'd7;
        @(negedge clock);
        load = 1'b0; start = 1'b0;
        chk_all("t6_load_wins", 12'h057, 3'b000);
        do_start();
        cyc(1);
        chk_all("t6_running", 12'h057, 3'b100);
        #2;
        reset = 1'b1;
        #1;
        chk_all("t6_async_rst", 12'h000, 3'b000);
        @(negedge clock);
        reset = 1'b0;
        cyc(3);
        chk_all("t6_after_rst", 12'h000, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
